// File: rtl/ace_instbuf.sv
// In-order instruction buffer between fetch stage 1 and decode: accepts up to eight
// aligned words per cycle, presents the four oldest to decode, clears on flush.
module ace_instbuf #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_rt_i,
  input  logic        inst0_vld_d0_i,
  input  logic        inst1_vld_d0_i,
  input  logic        inst2_vld_d0_i,
  input  logic        inst3_vld_d0_i,
  input  logic        inst4_vld_d0_i,
  input  logic        inst5_vld_d0_i,
  input  logic        inst6_vld_d0_i,
  input  logic        inst7_vld_d0_i,
  input  logic [31:0] inst0_d0_i,
  input  logic [31:0] inst1_d0_i,
  input  logic [31:0] inst2_d0_i,
  input  logic [31:0] inst3_d0_i,
  input  logic [31:0] inst4_d0_i,
  input  logic [31:0] inst5_d0_i,
  input  logic [31:0] inst6_d0_i,
  input  logic [31:0] inst7_d0_i,
  output logic        instbuf_full_o,
  input  logic [2:0]  dec_take_i,
  output logic        dec0_vld_o,
  output logic        dec1_vld_o,
  output logic        dec2_vld_o,
  output logic        dec3_vld_o,
  output logic [31:0] dec0_inst_o,
  output logic [31:0] dec1_inst_o,
  output logic [31:0] dec2_inst_o,
  output logic [31:0] dec3_inst_o,
  output logic [$clog2(DEPTH):0] instbuf_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]  vld_s;
  logic [31:0] lane_s [8];
  logic [3:0]  enq_n_s;
  logic        run_s;
  logic        accept_s;
  logic [2:0]  take_req_s;
  logic [2:0]  take_n_s;
  logic [3:0]  dvld_s;
  logic [31:0] dinst_s [4];

  assign vld_s = {inst7_vld_d0_i, inst6_vld_d0_i, inst5_vld_d0_i, inst4_vld_d0_i,
                  inst3_vld_d0_i, inst2_vld_d0_i, inst1_vld_d0_i, inst0_vld_d0_i};
  assign lane_s[0] = inst0_d0_i;
  assign lane_s[1] = inst1_d0_i;
  assign lane_s[2] = inst2_d0_i;
  assign lane_s[3] = inst3_d0_i;
  assign lane_s[4] = inst4_d0_i;
  assign lane_s[5] = inst5_d0_i;
  assign lane_s[6] = inst6_d0_i;
  assign lane_s[7] = inst7_d0_i;

  // Full means fewer than eight free slots, taken from registered occupancy only.
  assign instbuf_full_o = (cnt_q > CNT_W'(DEPTH - 8));
  assign accept_s       = ~instbuf_full_o;

  // Enqueue count is the run of valid lanes starting at lane 0.
  always_comb begin
    enq_n_s = 4'd0;
    run_s   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run_s && vld_s[i]) begin
        enq_n_s = enq_n_s + 4'd1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Dequeue count clamped to 4 and to the current occupancy.
  always_comb begin
    take_req_s = (dec_take_i > 3'd4) ? 3'd4 : dec_take_i;
    if (cnt_q < CNT_W'(take_req_s)) begin
      take_n_s = cnt_q[2:0];
    end else begin
      take_n_s = take_req_s;
    end
  end

  // Next-state pointers and occupancy from pre-edge state.
  always_comb begin
    head_d = head_q + PTR_W'(take_n_s);
    if (accept_s) begin
      tail_d = tail_q + PTR_W'(enq_n_s);
      cnt_d  = cnt_q + CNT_W'(enq_n_s) - CNT_W'(take_n_s);
    end else begin
      tail_d = tail_q;
      cnt_d  = cnt_q - CNT_W'(take_n_s);
    end
  end

  // Pointer/occupancy registers; reset beats flush, flush beats traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush_rt_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage is not reset; writes wrap naturally through the pointer width.
  always_ff @(posedge clock) begin
    if (!reset && !flush_rt_i && accept_s) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < enq_n_s) begin
          mem_q[tail_q + PTR_W'(i)] <= lane_s[i];
        end
      end
    end
  end

  // Decode view of the four oldest entries, zeroed when not valid.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dvld_s[k] = (CNT_W'(k) < cnt_q);
      if (dvld_s[k]) begin
        dinst_s[k] = mem_q[head_q + PTR_W'(k)];
      end else begin
        dinst_s[k] = 32'h0;
      end
    end
  end

  assign dec0_vld_o    = dvld_s[0];
  assign dec1_vld_o    = dvld_s[1];
  assign dec2_vld_o    = dvld_s[2];
  assign dec3_vld_o    = dvld_s[3];
  assign dec0_inst_o   = dinst_s[0];
  assign dec1_inst_o   = dinst_s[1];
  assign dec2_inst_o   = dinst_s[2];
  assign dec3_inst_o   = dinst_s[3];
  assign instbuf_cnt_o = cnt_q;

endmodule

// File: tb/tb_ace_instbuf.sv
// Scoreboard bench for ace_instbuf: a queue-based reference model predicts the
// post-edge decode view; a monitor compares it against the DUT each cycle.
module tb_ace_instbuf;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [7:0]  vld;
  logic [31:0] w [8];
  logic [2:0]  take;
  logic        full;
  logic [3:0]  dvld;
  logic [31:0] dinst [4];
  logic [5:0]  cnt;

  typedef struct packed {
    logic [5:0]       cnt;
    logic             full;
    logic [3:0]       vld;
    logic [3:0][31:0] inst;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mq [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  ace_instbuf #(.DEPTH(32)) dut (
    .clock(clock), .reset(reset), .flush_rt_i(flush),
    .inst0_vld_d0_i(vld[0]), .inst1_vld_d0_i(vld[1]), .inst2_vld_d0_i(vld[2]), .inst3_vld_d0_i(vld[3]),
    .inst4_vld_d0_i(vld[4]), .inst5_vld_d0_i(vld[5]), .inst6_vld_d0_i(vld[6]), .inst7_vld_d0_i(vld[7]),
    .inst0_d0_i(w[0]), .inst1_d0_i(w[1]), .inst2_d0_i(w[2]), .inst3_d0_i(w[3]),
    .inst4_d0_i(w[4]), .inst5_d0_i(w[5]), .inst6_d0_i(w[6]), .inst7_d0_i(w[7]),
    .instbuf_full_o(full), .dec_take_i(take),
    .dec0_vld_o(dvld[0]), .dec1_vld_o(dvld[1]), .dec2_vld_o(dvld[2]), .dec3_vld_o(dvld[3]),
    .dec0_inst_o(dinst[0]), .dec1_inst_o(dinst[1]), .dec2_inst_o(dinst[2]), .dec3_inst_o(dinst[3]),
    .instbuf_cnt_o(cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // One cycle of stimulus: drive at negedge, advance the model, queue the expected view.
  task automatic step(input logic [7:0] mask, input logic [31:0] base, input int tk,
                      input bit fl, input bit rs);
    int   n;
    int   tn;
    bit   full_m;
    exp_t e;
    @(negedge clock);
    reset = rs;
    flush = fl;
    vld   = mask;
    take  = 3'(tk);
    for (int i = 0; i < 8; i++) w[i] = base + 32'(i);
    full_m = (32 - mq.size()) < 8;
    if (rs || fl) begin
      mq.delete();
    end else begin
      tn = (tk > 4) ? 4 : tk;
      if (tn > mq.size()) tn = mq.size();
      n = 0;
      while (n < 8 && mask[n]) n++;
      for (int i = 0; i < tn; i++) void'(mq.pop_front());
      if (!full_m) for (int i = 0; i < n; i++) mq.push_back(base + 32'(i));
    end
    e.cnt  = 6'(mq.size());
    e.full = (32 - mq.size()) < 8;
    for (int k = 0; k < 4; k++) begin
      e.vld[k]  = (k < mq.size());
      e.inst[k] = (k < mq.size()) ? mq[k] : 32'h0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT view with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt", 32'(cnt), 32'(e.cnt));
        check("full", 32'(full), 32'(e.full));
        for (int k = 0; k < 4; k++) begin
          check($sformatf("dec%0d_vld", k), 32'(dvld[k]), 32'(e.vld[k]));
          check($sformatf("dec%0d_inst", k), dinst[k], e.inst[k]);
        end
      end
    end
  end

  initial begin
    logic [7:0]  gmask;
    logic [31:0] gbase;
    bit          rs;
    bit          fl;
    int          wait_cyc;
    reset = 1'b1; flush = 1'b0; vld = 8'h00; take = 3'd0;
    for (int i = 0; i < 8; i++) w[i] = 32'h0;

    // Basic enqueue then take.
    step(8'h00, 32'h0, 0, 0, 1);
    step(8'hff, 32'h100, 0, 0, 0);
    step(8'h00, 32'h0, 0, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    // Partial masks and over-take.
    step(8'h07, 32'h300, 0, 0, 0);
    step(8'h0b, 32'h310, 0, 0, 0);
    step(8'h00, 32'h0, 7, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    step(8'h03, 32'h320, 0, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    // Fill to full, hold a fifth group until space opens.
    step(8'h00, 32'h0, 0, 0, 1);
    for (int g = 0; g < 4; g++) step(8'hff, 32'h400 + 32'(8 * g), 0, 0, 0);
    step(8'hff, 32'h500, 0, 0, 0);
    step(8'hff, 32'h500, 4, 0, 0);
    step(8'hff, 32'h500, 4, 0, 0);
    step(8'hff, 32'h500, 0, 0, 0);
    step(8'h00, 32'h0, 0, 0, 0);
    // Wrap-around at index 28.
    step(8'h00, 32'h0, 0, 0, 1);
    for (int g = 0; g < 3; g++) step(8'hff, 32'h440 + 32'(8 * g), 0, 0, 0);
    step(8'h0f, 32'h460, 0, 0, 0);
    for (int t = 0; t < 7; t++) step(8'h00, 32'h0, 4, 0, 0);
    step(8'hff, 32'h200, 0, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    step(8'h00, 32'h0, 4, 0, 0);
    // Flush and reset with concurrent traffic.
    step(8'hff, 32'h600, 0, 0, 0);
    step(8'h0f, 32'h610, 0, 0, 0);
    step(8'hff, 32'h700, 4, 1, 0);
    step(8'hff, 32'h708, 2, 1, 0);
    step(8'hff, 32'h800, 0, 0, 0);
    step(8'hff, 32'h900, 4, 0, 1);
    step(8'h00, 32'h0, 0, 0, 0);

    // Randomized traffic; fetch holds its group while the model says full.
    gmask = 8'hff; gbase = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      if (!((32 - mq.size()) < 8)) begin
        gmask = 8'($urandom());
        if ($urandom_range(0, 3) == 0) gmask = 8'hff;
        gbase = $urandom();
      end
      rs = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 31) == 0);
      step(gmask, gbase, $urandom_range(0, 7), fl, rs);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clock);
      wait_cyc++;
    end
    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
